// File: rtl/aes_gcm_output_stage.sv
// AES-GCM output stage: buffers ciphertext blocks and the final tag of each
// GCM instance in a small FIFO, streams them out on valid/ready with the tag
// as the last word, and optionally reports a tag verification result.
module aes_gcm_output_stage #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_new_instance,
   input  logic           i_valid,
   input  logic [127:0]   i_cipher_text,
   input  logic           i_tag_ready,
   input  logic [127:0]   i_tag,
   input  logic           i_verify_en,
   input  logic [127:0]   i_expected_tag,
   output logic [127:0]   o_data,
   output logic           o_valid,
   input  logic           i_ready,
   output logic           o_is_tag,
   output logic           o_last,
   output logic           o_auth_valid,
   output logic           o_auth_ok,
   output logic [CW-1:0]  o_count,
   output logic           o_error
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_STREAM   = 2'd1;
   localparam logic [1:0] S_TAG_HOLD = 2'd2;
   localparam logic [1:0] S_DRAIN    = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [127:0]  memData_q [DEPTH];
   logic          memTag_q  [DEPTH];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [CW-1:0] count_q;
   logic [127:0]  hold_q;
   logic          error_q;
   logic          authValid_q;
   logic          authOk_q;

   logic          fifoValid, headTag, pop, full, space, acceptNew;
   logic          push, pushTag, holdLoad, setError, tagAccept;
   logic [127:0]  pushData;

   assign fifoValid = (count_q != '0);
   assign headTag   = memTag_q[rdPtr_q];
   assign pop       = fifoValid && i_ready;
   assign full      = (count_q == CW'(DEPTH));
   // A same-cycle pop frees the slot the push needs, even when full.
   assign space     = !full || pop;
   // Popping the tag ends the instance, so a new one may start that cycle.
   assign acceptNew = (state_q == S_IDLE) ||
                      ((state_q == S_DRAIN) && pop && headTag);

   // Next-state, push selection and protocol error detection.
   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      pushTag   = 1'b0;
      pushData  = '0;
      holdLoad  = 1'b0;
      setError  = 1'b0;
      tagAccept = 1'b0;
      if (acceptNew) begin
         state_d = S_IDLE;
         if (i_new_instance) begin
            state_d = S_STREAM;
            if (i_valid) begin
               if (space) begin
                  push     = 1'b1;
                  pushData = i_cipher_text;
               end else begin
                  setError = 1'b1;
               end
            end
         end else if (i_valid) begin
            setError = 1'b1;
         end
      end else begin
         case (state_q)
            S_STREAM: begin
               if (i_tag_ready) begin
                  tagAccept = 1'b1;
                  if (space) begin
                     push     = 1'b1;
                     pushTag  = 1'b1;
                     pushData = i_tag;
                     state_d  = S_DRAIN;
                  end else begin
                     holdLoad = 1'b1;
                     state_d  = S_TAG_HOLD;
                  end
               end else if (i_valid) begin
                  if (space) begin
                     push     = 1'b1;
                     pushData = i_cipher_text;
                  end else begin
                     setError = 1'b1;
                  end
               end
               if (i_new_instance) setError = 1'b1;
            end
            S_TAG_HOLD: begin
               if (space) begin
                  push     = 1'b1;
                  pushTag  = 1'b1;
                  pushData = hold_q;
                  state_d  = S_DRAIN;
               end
               if (i_valid || i_tag_ready) setError = 1'b1;
            end
            S_DRAIN: begin
               if (i_valid || i_tag_ready || i_new_instance) setError = 1'b1;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // FIFO storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         memData_q[wrPtr_q] <= pushData;
         memTag_q[wrPtr_q]  <= pushTag;
      end
   end

   // Control state: FSM, pointers, occupancy, tag hold, error and verify.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         hold_q      <= '0;
         error_q     <= 1'b0;
         authValid_q <= 1'b0;
         authOk_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wrPtr_q <= wrPtr_q + AW'(1);
         if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (!push && pop) count_q <= count_q - CW'(1);
         if (holdLoad) hold_q <= i_tag;
         if (setError) error_q <= 1'b1;
         authValid_q <= tagAccept && i_verify_en;
         if (tagAccept && i_verify_en) authOk_q <= (i_tag == i_expected_tag);
      end
   end

   assign o_valid      = fifoValid;
   assign o_data       = fifoValid ? memData_q[rdPtr_q] : '0;
   assign o_is_tag     = fifoValid && headTag;
   assign o_last       = o_is_tag;
   assign o_count      = count_q;
   assign o_error      = error_q;
   assign o_auth_valid = authValid_q;
   assign o_auth_ok    = authOk_q;

endmodule

// File: doc/aes_gcm_output_stage.md
Name: aes_gcm_output_stage

Overview:
- Sits directly downstream of the GHASH/tag stage (pipeline stage 8) at the tail of the AES-GCM pipeline.
- Buffers the per-block ciphertext and the final tag in a small FIFO.
- Presents the buffered words on a valid/ready output stream, with the tag as the last word of each instance.
- Optionally compares the computed tag against an expected tag (decrypt-verify) and reports pass/fail.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_new_instance  in  1  first block of a new GCM instance (same cycle alignment as upstream).
- i_valid  in  1  i_cipher_text carries a payload block this cycle.
- i_cipher_text  in  128  ciphertext block from stage 8; bit 0 is MSB.
- i_tag_ready  in  1  one-cycle pulse from stage 8: i_tag is final this cycle.
- i_tag  in  128  computed tag from stage 8.
- i_verify_en  in  1  compare the tag on the i_tag_ready cycle.
- i_expected_tag  in  128  reference tag for verification.
- o_data  out  128  head-of-FIFO word.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.
- o_is_tag  out  1  head word is the tag.
- o_last  out  1  head word is the last word of the instance; equals o_is_tag.
- o_auth_valid  out  1  one-cycle pulse carrying the verify result.
- o_auth_ok  out  1  verify result; held until the next o_auth_valid pulse.
- o_count  out  CW  FIFO occupancy.
- o_error  out  1  sticky error flag (overflow or protocol error); cleared only by rst.

Behaviour:
- Reset (synchronous, active-high): state=S_IDLE, FIFO empty, o_count=0, o_valid=0, o_is_tag=0, o_last=0, o_data=0, o_auth_valid=0, o_auth_ok=0, o_error=0, tag hold register cleared. Reset asserted mid-instance discards all buffered data and any pending tag.
- Storage:
  - FIFO entry = {data[128], is_tag}.
  - Output is registered with no fall-through: a word pushed in cycle N is visible on o_data/o_valid no earlier than N+1.
  - Pop occurs when o_valid && i_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full; o_count is then unchanged.
- FSM states: S_IDLE, S_STREAM, S_TAG_HOLD, S_DRAIN.
- S_IDLE:
  - i_new_instance -> S_STREAM; the same-cycle i_valid block is pushed.
  - i_valid without i_new_instance: block dropped, o_error=1.
- S_STREAM:
  - i_valid && !i_tag_ready: push the block (is_tag=0).
  - i_tag_ready: the same-cycle i_cipher_text is the length block, not payload, and is never pushed regardless of i_valid.
  - On i_tag_ready, if there is space after a same-cycle pop, push i_tag with is_tag=1 -> S_DRAIN. Otherwise latch i_tag into the hold register -> S_TAG_HOLD.
  - i_new_instance: o_error=1; the current instance continues.
- S_TAG_HOLD:
  - Push the held tag in the first cycle that has space -> S_DRAIN.
  - Any i_valid or i_tag_ready arriving here is ignored and sets o_error.
- S_DRAIN:
  - Pops continue normally.
  - When the tag entry is popped -> S_IDLE. In that same cycle, i_new_instance is accepted as from S_IDLE (-> S_STREAM, push allowed).
  - Otherwise i_valid, i_tag_ready or i_new_instance sets o_error and is dropped.
- Overflow: a payload push while the FIFO is full with no same-cycle pop drops the block and sets o_error. The FIFO contents stay intact.
- Verify:
  - On an accepted i_tag_ready with i_verify_en=1, register the comparison (i_tag == i_expected_tag, all 128 bits).
  - One cycle later: o_auth_valid=1 for exactly one cycle, o_auth_ok=comparison result.
  - With i_verify_en=0: no pulse; o_auth_ok keeps its previous value.
  - Verify timing is independent of FIFO space (a tag in S_TAG_HOLD still reports on time).
- Pointers wrap modulo DEPTH; o_count ranges 0..DEPTH.

Test Plan:
1. Reset, then i_new_instance+i_valid with blocks 0x..01, 0x..02, 0x..03 in consecutive cycles, then i_tag_ready with i_tag=0xAA..AA, i_ready=1 -> o_data 01,02,03,AA..AA on consecutive cycles, first o_valid one cycle after the first push; o_is_tag=o_last=1 only on AA..AA; o_error=0.
2. Same stream with i_verify_en=1 and i_expected_tag=i_tag, then a repeat run with expected differing in bit 127 -> o_auth_valid pulse exactly one cycle after i_tag_ready; o_auth_ok=1, then 0.
3. DEPTH=8, i_ready=0, push 8 blocks, then i_tag_ready -> o_count=8, state S_TAG_HOLD; raise i_ready -> 8 blocks, then the tag, drain in order; o_error=0.
4. FIFO full, i_ready=0, push a 9th block -> block dropped, o_error=1 and stays 1 until rst; the first 8 words are unchanged.
5. i_tag_ready and i_valid in the same cycle with i_cipher_text=0x55..55 -> 0x55..55 never appears on o_data.
6. Assert rst mid-stream with o_count=5 and a tag held -> next cycle o_valid=0, o_count=0, o_error=0; a fresh instance streams correctly.
